// File: rtl/pointer_seq.sv
// -----------------------------------------------------------------------------
// pointer_seq
//   Command sequencer for one external 16-bit pointer register. It accepts
//   byte-wide commands over a valid/ready handshake and drives the pointer's
//   byte-load strobes, output enables and count enable, plus the memory read
//   strobe used by auto-incrementing bursts.
//
//   Commands (cmd_op):
//     2'b00 LDL   load pointer low byte with cmd_data
//     2'b01 LDH   load pointer high byte with cmd_data
//     2'b10 BURST cmd_data beats (0 means 256), pointer increments per beat
//     2'b11 DUMP  pointer low byte, then high byte, onto the data bus
//
// Ports
//   clk        in   rising-edge clock
//   n_rst      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_op     in   [1:0] command opcode
//   cmd_data   in   [7:0] load byte or burst beat count
//   cmd_ready  out  high only when idle
//   abort      in   synchronous abort, forces idle on the next edge
//   di         out  [7:0] byte presented to the pointer load inputs
//   n_we_l     out  pointer low-byte load, active low
//   n_we_h     out  pointer high-byte load, active low
//   cnt        out  pointer increment enable
//   n_oe_addr  out  pointer drives address bus, active low
//   n_oe_dl    out  pointer low byte drives data bus, active low
//   n_oe_dh    out  pointer high byte drives data bus, active low
//   n_mem_rd   out  memory read strobe, active low
//   beat       out  one-cycle pulse in the last address cycle of a beat
//   busy       out  high whenever not idle
//
// All outputs come straight from flops: the combinational block computes the
// next state and the strobe values belonging to that next state, and both
// are captured on the same edge.
// -----------------------------------------------------------------------------
module pointer_seq #(
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       abort,
  output logic [7:0] di,
  output logic       n_we_l,
  output logic       n_we_h,
  output logic       cnt,
  output logic       n_oe_addr,
  output logic       n_oe_dl,
  output logic       n_oe_dh,
  output logic       n_mem_rd,
  output logic       beat,
  output logic       busy
);

  // Wait states beyond 3 are clamped; negative values behave as 0.
  localparam logic [1:0] WS_MAX = (WAIT_STATES > 3) ? 2'd3 :
                                  (WAIT_STATES < 0) ? 2'd0 : 2'(WAIT_STATES);

  localparam logic [1:0] OP_LDL   = 2'b00;
  localparam logic [1:0] OP_LDH   = 2'b01;
  localparam logic [1:0] OP_BURST = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_BURST_A = 3'd2,
    ST_BURST_I = 3'd3,
    ST_DUMP_L  = 3'd4,
    ST_DUMP_H  = 3'd5
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [8:0] rem_r;
  logic [8:0] rem_s;
  logic [1:0] ws_r;
  logic [1:0] ws_s;

  logic [7:0] di_s;
  logic       n_we_l_s;
  logic       n_we_h_s;
  logic       cnt_s;
  logic       n_oe_addr_s;
  logic       n_oe_dl_s;
  logic       n_oe_dh_s;
  logic       n_mem_rd_s;
  logic       beat_s;
  logic       cmd_ready_s;
  logic       busy_s;

  // Next-state logic and strobe values for the cycle that the next state occupies.
  always_comb begin
    state_s     = state_r;
    rem_s       = rem_r;
    ws_s        = ws_r;
    di_s        = di;
    n_we_l_s    = 1'b1;
    n_we_h_s    = 1'b1;
    cnt_s       = 1'b0;
    n_oe_addr_s = 1'b1;
    n_oe_dl_s   = 1'b1;
    n_oe_dh_s   = 1'b1;
    n_mem_rd_s  = 1'b1;
    beat_s      = 1'b0;

    if (abort) begin
      // Abort beats everything, including a command offered in idle.
      state_s = ST_IDLE;
      rem_s   = 9'd0;
      ws_s    = 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LDL: begin
                state_s  = ST_LOAD;
                di_s     = cmd_data;
                n_we_l_s = 1'b0;
              end
              OP_LDH: begin
                state_s  = ST_LOAD;
                di_s     = cmd_data;
                n_we_h_s = 1'b0;
              end
              OP_BURST: begin
                state_s = ST_BURST_A;
                rem_s   = (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
                ws_s    = 2'd0;
              end
              OP_DUMP: begin
                state_s = ST_DUMP_L;
              end
              default: begin
                state_s = ST_IDLE;
              end
            endcase
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_s = ST_IDLE;
        end
        ST_BURST_A: begin
          // ws_r counts address-phase cycles already spent in this beat.
          if (ws_r == WS_MAX) begin
            state_s = ST_BURST_I;
            ws_s    = 2'd0;
          end else begin
            state_s = ST_BURST_A;
            ws_s    = ws_r + 2'd1;
          end
        end
        ST_BURST_I: begin
          rem_s = rem_r - 9'd1;
          if (rem_s != 9'd0) begin
            state_s = ST_BURST_A;
            ws_s    = 2'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DUMP_L: begin
          state_s = ST_DUMP_H;
        end
        ST_DUMP_H: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
          rem_s   = 9'd0;
          ws_s    = 2'd0;
        end
      endcase
    end

    // Bus strobes follow the state they are registered into.
    case (state_s)
      ST_BURST_A: begin
        n_oe_addr_s = 1'b0;
        n_mem_rd_s  = 1'b0;
        beat_s      = (ws_s == WS_MAX);
      end
      ST_BURST_I: begin
        cnt_s = 1'b1;
      end
      ST_DUMP_L: begin
        n_oe_dl_s = 1'b0;
      end
      ST_DUMP_H: begin
        n_oe_dh_s = 1'b0;
      end
      default: begin
        cnt_s = 1'b0;
      end
    endcase

    cmd_ready_s = (state_s == ST_IDLE);
    busy_s      = (state_s != ST_IDLE);
  end

  // State, burst counters and all registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= ST_IDLE;
      rem_r     <= 9'd0;
      ws_r      <= 2'd0;
      di        <= 8'h00;
      n_we_l    <= 1'b1;
      n_we_h    <= 1'b1;
      cnt       <= 1'b0;
      n_oe_addr <= 1'b1;
      n_oe_dl   <= 1'b1;
      n_oe_dh   <= 1'b1;
      n_mem_rd  <= 1'b1;
      beat      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      rem_r     <= rem_s;
      ws_r      <= ws_s;
      di        <= di_s;
      n_we_l    <= n_we_l_s;
      n_we_h    <= n_we_h_s;
      cnt       <= cnt_s;
      n_oe_addr <= n_oe_addr_s;
      n_oe_dl   <= n_oe_dl_s;
      n_oe_dh   <= n_oe_dh_s;
      n_mem_rd  <= n_mem_rd_s;
      beat      <= beat_s;
      cmd_ready <= cmd_ready_s;
      busy      <= busy_s;
    end
  end

endmodule

// File: tb/tb_pointer_seq.sv
// -----------------------------------------------------------------------------
// tb_pointer_seq
//   Directed bench for pointer_seq. A behavioural model of the external 16-bit
//   pointer register reacts to the sequencer's strobes; expected values are
//   hand-computed. A second instance with WAIT_STATES=5 (clamped to 3)
//   exercises the address-phase stretching.
// -----------------------------------------------------------------------------
module tb_pointer_seq;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       abort;
  logic [7:0] di;
  logic       n_we_l, n_we_h, cnt, n_oe_addr, n_oe_dl, n_oe_dh, n_mem_rd, beat, busy;

  logic       cmd_valid2;
  logic [1:0] cmd_op2;
  logic [7:0] cmd_data2;
  logic       cmd_ready2;
  logic       abort2;
  logic [7:0] di2;
  logic       n_we_l2, n_we_h2, cnt2, n_oe_addr2, n_oe_dl2, n_oe_dh2, n_mem_rd2, beat2, busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  logic [15:0] ptr = 16'h0000;
  logic [7:0]  dbus;
  logic [15:0] addrs [0:3];
  int          busy_c, beat_c, weh_c, rd_c, first_beat;

  always #5 clk = ~clk;

  pointer_seq #(.WAIT_STATES(0)) dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .abort(abort), .di(di),
    .n_we_l(n_we_l), .n_we_h(n_we_h), .cnt(cnt), .n_oe_addr(n_oe_addr),
    .n_oe_dl(n_oe_dl), .n_oe_dh(n_oe_dh), .n_mem_rd(n_mem_rd), .beat(beat),
    .busy(busy)
  );

  pointer_seq #(.WAIT_STATES(5)) dut2 (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid2), .cmd_op(cmd_op2),
    .cmd_data(cmd_data2), .cmd_ready(cmd_ready2), .abort(abort2), .di(di2),
    .n_we_l(n_we_l2), .n_we_h(n_we_h2), .cnt(cnt2), .n_oe_addr(n_oe_addr2),
    .n_oe_dl(n_oe_dl2), .n_oe_dh(n_oe_dh2), .n_mem_rd(n_mem_rd2), .beat(beat2),
    .busy(busy2)
  );

  // External pointer register driven by the sequencer's strobes.
  always @(posedge clk) begin
    if (!n_we_l) ptr[7:0] <= di;
    if (!n_we_h) ptr[15:8] <= di;
    if (cnt) ptr <= ptr + 16'd1;
  end

  // Data bus as seen when the pointer drives it.
  assign dbus = !n_oe_dl ? ptr[7:0] : (!n_oe_dh ? ptr[15:8] : 8'h00);

  // Strobe exclusivity monitor.
  always @(negedge clk) begin
    if (n_rst) begin
      if ((32'(!n_oe_addr) + 32'(!n_oe_dl) + 32'(!n_oe_dh)) > 32'd1) viol <= viol + 1;
      else if (cnt && (!n_we_l || !n_we_h)) viol <= viol + 1;
      else if (!n_we_l && !n_we_h) viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first strobe cycle.
  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    check("ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_burst(input logic [7:0] n);
    issue(2'b10, n);
    busy_c = 0;
    beat_c = 0;
    for (int k = 0; k < 3000 && busy; k++) begin
      busy_c++;
      if (beat) begin
        if (beat_c < 4) addrs[beat_c] = n_oe_addr ? 16'hxxxx : ptr;
        beat_c++;
      end
      @(negedge clk);
    end
    if (busy) check("burst_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; abort = 1'b0;
    cmd_valid2 = 1'b0; cmd_op2 = 2'b00; cmd_data2 = 8'h00; abort2 = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_di", 32'(di), 32'h00);
    check("rst_strobes", 32'({n_we_l, n_we_h, n_oe_addr, n_oe_dl, n_oe_dh, n_mem_rd, cnt, beat}), 32'b11111100);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // 1. LDL 0x34 then LDH 0x12
    issue(2'b00, 8'h34);
    check("ldl_we_l", 32'(n_we_l), 32'd0);
    check("ldl_we_h", 32'(n_we_h), 32'd1);
    check("ldl_di", 32'(di), 32'h34);
    check("ldl_busy", 32'(busy), 32'd1);
    check("ldl_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("ldl_done_we_l", 32'(n_we_l), 32'd1);
    check("ldl_done_busy", 32'(busy), 32'd0);
    issue(2'b01, 8'h12);
    check("ldh_we_h", 32'(n_we_h), 32'd0);
    check("ldh_we_l", 32'(n_we_l), 32'd1);
    check("ldh_di", 32'(di), 32'h12);
    @(negedge clk);
    check("ptr_1234", 32'(ptr), 32'h1234);

    // 2. BURST 3 from 0x12FE
    issue(2'b00, 8'hFE);
    @(negedge clk);
    run_burst(8'd3);
    check("b3_busy_cycles", 32'(busy_c), 32'd6);
    check("b3_beats", 32'(beat_c), 32'd3);
    check("b3_addr0", 32'(addrs[0]), 32'h12FE);
    check("b3_addr1", 32'(addrs[1]), 32'h12FF);
    check("b3_addr2", 32'(addrs[2]), 32'h1300);
    check("b3_ptr", 32'(ptr), 32'h1301);

    // 3. BURST 0 (256 beats) from 0xFFFF
    issue(2'b00, 8'hFF);
    @(negedge clk);
    issue(2'b01, 8'hFF);
    @(negedge clk);
    run_burst(8'd0);
    check("b256_busy_cycles", 32'(busy_c), 32'd512);
    check("b256_beats", 32'(beat_c), 32'd256);
    check("b256_addr0", 32'(addrs[0]), 32'hFFFF);
    check("b256_addr1", 32'(addrs[1]), 32'h0000);
    check("b256_ptr", 32'(ptr), 32'h00FF);

    // 4. DUMP of 0xBEEF
    issue(2'b00, 8'hEF);
    @(negedge clk);
    issue(2'b01, 8'hBE);
    @(negedge clk);
    issue(2'b11, 8'h00);
    check("dump_l_oe", 32'({n_oe_dl, n_oe_dh, n_oe_addr}), 32'b011);
    check("dump_l_bus", 32'(dbus), 32'hEF);
    @(negedge clk);
    check("dump_h_oe", 32'({n_oe_dl, n_oe_dh, n_oe_addr}), 32'b101);
    check("dump_h_bus", 32'(dbus), 32'hBE);
    @(negedge clk);
    check("dump_done_busy", 32'(busy), 32'd0);

    // 5. Abort during the 2nd BURST_A of BURST 5
    issue(2'b10, 8'd5);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_a2", 32'({n_oe_addr, n_mem_rd, beat}), 32'b001);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_strobes", 32'({n_oe_addr, n_mem_rd, cnt, beat}), 32'b1100);
    check("abort_ptr", 32'(ptr), 32'hBEF0);
    abort = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'hAA;
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    check("abort_beats_cmd", 32'({busy, n_we_l}), 32'b01);
    issue(2'b00, 8'h55);
    check("post_abort_ldl", 32'({n_we_l, di}), 32'h055);
    @(negedge clk);
    check("post_abort_ptr", 32'(ptr), 32'hBE55);

    // 6. Reset mid-burst, then a command held across a busy period
    issue(2'b10, 8'd4);
    @(negedge clk);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_di", 32'(di), 32'h00);
    check("midrst_strobes", 32'({n_oe_addr, n_mem_rd, cnt, beat}), 32'b1100);
    @(negedge clk);
    n_rst = 1'b1;
    check("midrst_ptr", 32'(ptr), 32'hBE56);
    @(negedge clk);
    issue(2'b10, 8'd2);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'h77;
    busy_c = 0;
    weh_c  = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy) busy_c++;
      if (!n_we_h) weh_c++;
      if (cmd_valid && cmd_ready) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("held_busy_cycles", 32'(busy_c), 32'd5);
    check("held_we_h_count", 32'(weh_c), 32'd1);
    check("held_ptr", 32'(ptr), 32'h7758);

    // Clamped wait states: BURST 2 with WAIT_STATES=5 behaves as 3
    cmd_valid2 = 1'b1; cmd_op2 = 2'b10; cmd_data2 = 8'd2;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    busy_c = 0; beat_c = 0; rd_c = 0; first_beat = 0;
    for (int k = 0; k < 100 && busy2; k++) begin
      busy_c++;
      if (!n_mem_rd2) rd_c++;
      if (beat2) begin
        beat_c++;
        if (first_beat == 0) first_beat = busy_c;
      end
      @(negedge clk);
    end
    check("ws_busy_cycles", 32'(busy_c), 32'd10);
    check("ws_beats", 32'(beat_c), 32'd2);
    check("ws_first_beat", 32'(first_beat), 32'd4);
    check("ws_rd_cycles", 32'(rd_c), 32'd8);

    check("mutex_violations", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
